// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA output collector: FSM encoding, counter width
// and the helper that locates a row's word inside the packed row bus.
package rsa_pkg;

  localparam int CNT_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Rows are numbered from 1; row r occupies bits [(r-1)*width +: width].
  function automatic int slice_lo(input int row, input int width);
    return (row - 1) * width;
  endfunction

endpackage

// File: rtl/rsa_out_collector_if.sv
// Result stream of the output collector: valid/ready word port with a last marker.
interface rsa_out_collector_if #(
  parameter int OUT_LEN = 8
) ();

  logic [OUT_LEN-1:0] res_data;
  logic               res_val;
  logic               res_rdy;
  logic               res_last;

  modport master (
    output res_data,
    output res_val,
    output res_last,
    input  res_rdy
  );

  modport slave (
    input  res_data,
    input  res_val,
    input  res_last,
    output res_rdy
  );

endinterface

// File: rtl/rsa_row_fifo.sv
// Per-row synchronous FIFO. A push into a full FIFO is still taken when the same
// cycle pops, so a steadily drained row never loses a word.
module rsa_row_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic          do_pop;
  logic          do_push;

  // The extra pointer bit distinguishes a wrapped (full) FIFO from an empty one.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/rsa_out_collector.sv
// Collects staggered per-row PE outputs into row buffers and replays them as a
// row-major m x k result stream on a back-pressured valid/ready port.
module rsa_out_collector
  import rsa_pkg::*;
#(
  parameter int X       = 3,
  parameter int Y       = 3,
  parameter int OUT_LEN = 8,
  parameter int DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 sys_rst_n,
  input  logic                 cfg_val,
  input  logic [CNT_W-1:0]     cfg_m,
  input  logic [CNT_W-1:0]     cfg_k,
  input  logic [X-1:0]         out_rd_en,
  input  logic [X*OUT_LEN-1:0] row_data,
  output logic                 pe_out_rdy,
  rsa_out_collector_if.master  res,
  output logic                 done,
  output logic                 cfg_err,
  output logic                 ovf
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     m_q, k_q;
  logic [CNT_W-1:0]     r_q, r_d;
  logic [CNT_W-1:0]     c_q, c_d;
  logic [X-1:0]         d_rd_en_q;
  logic [X-1:0]         push;
  logic [X-1:0]         pop;
  logic [X-1:0]         full;
  logic [X-1:0]         empty;
  logic [OUT_LEN-1:0]   fifo_dout [X];
  logic                 out_val_q;
  logic [OUT_LEN-1:0]   out_data_q;
  logic [OUT_LEN-1:0]   load_data;
  logic                 done_q;
  logic                 cfg_err_q;
  logic                 ovf_q;
  logic                 cfg_legal;
  logic                 cfg_accept;
  logic                 xfer;
  logic                 is_last;
  logic                 can_load;
  logic                 load;
  logic                 ovf_set;

  assign cfg_legal  = (cfg_m >= CNT_W'(1)) && (cfg_m <= CNT_W'(X)) &&
                      (cfg_k >= CNT_W'(1)) && (cfg_k <= CNT_W'(Y));
  assign cfg_accept = cfg_val && (state_q == IDLE) && cfg_legal;
  assign xfer       = out_val_q && res.res_rdy;
  assign is_last    = (r_q == m_q) && (c_q == k_q);

  // r/c always name the element sitting in (or next due for) the output register.
  always_comb begin
    r_d = r_q;
    c_d = c_q;
    if (xfer) begin
      if (c_q == k_q) begin
        c_d = CNT_W'(1);
        r_d = r_q + 1'b1;
      end else begin
        c_d = c_q + 1'b1;
      end
    end
  end

  // Refill on an empty register or on the very cycle its word leaves, unless it was the last word.
  assign can_load = (state_q == ACTIVE) && (!out_val_q || (xfer && !is_last));

  for (genvar i = 0; i < X; i++) begin : g_row
    assign push[i] = (state_q == ACTIVE) && d_rd_en_q[i] && (CNT_W'(i + 1) <= m_q);
    assign pop[i]  = can_load && (r_d == CNT_W'(i + 1)) && !empty[i];

    rsa_row_fifo #(
      .W     (OUT_LEN),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (sys_rst_n),
      .clr_i   (cfg_accept),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .data_i  (row_data[slice_lo(i + 1, OUT_LEN) +: OUT_LEN]),
      .data_o  (fifo_dout[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );
  end

  assign load    = |pop;
  assign ovf_set = |(push & full & ~pop);

  always_comb begin
    load_data = '0;
    for (int i = 0; i < X; i++) begin
      if (pop[i]) load_data = fifo_dout[i];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_accept)       state_d = ACTIVE;
      ACTIVE:  if (xfer && is_last)  state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A newly accepted job restarts from a clean slate: counters, capture strobes, output and ovf.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_q        <= '0;
      k_q        <= '0;
      r_q        <= '0;
      c_q        <= '0;
      d_rd_en_q  <= '0;
      out_val_q  <= 1'b0;
      out_data_q <= '0;
      ovf_q      <= 1'b0;
    end else if (cfg_accept) begin
      m_q        <= cfg_m;
      k_q        <= cfg_k;
      r_q        <= CNT_W'(1);
      c_q        <= CNT_W'(1);
      d_rd_en_q  <= '0;
      out_val_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      r_q       <= r_d;
      c_q       <= c_d;
      d_rd_en_q <= (state_q == ACTIVE) ? out_rd_en : '0;
      if (load) begin
        out_val_q  <= 1'b1;
        out_data_q <= load_data;
      end else if (xfer) begin
        out_val_q  <= 1'b0;
      end
      if (ovf_set) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      done_q    <= xfer && is_last;
      cfg_err_q <= cfg_val && !cfg_accept;
    end
  end

  assign pe_out_rdy   = (state_q == ACTIVE);
  assign res.res_val  = out_val_q;
  assign res.res_data = out_data_q;
  assign res.res_last = out_val_q && is_last;
  assign done         = done_q;
  assign cfg_err      = cfg_err_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_rsa_out_collector.sv
// Randomised and directed bench for rsa_out_collector, checked every cycle against
// a queue-based model of the expected row-major result stream.
module tb_rsa_out_collector;
  import rsa_pkg::*;

  localparam int X       = 3;
  localparam int Y       = 3;
  localparam int OUT_LEN = 8;
  localparam int DEPTH   = 4;
  localparam int QMAX    = 32;

  logic                 clk = 1'b0;
  logic                 sys_rst_n;
  logic                 cfg_val;
  logic [CNT_W-1:0]     cfg_m;
  logic [CNT_W-1:0]     cfg_k;
  logic [X-1:0]         out_rd_en;
  logic [X*OUT_LEN-1:0] row_data;
  logic                 pe_out_rdy;
  logic                 done;
  logic                 cfg_err;
  logic                 ovf;

  rsa_out_collector_if #(.OUT_LEN(OUT_LEN)) resIf ();

  rsa_out_collector #(
    .X       (X),
    .Y       (Y),
    .OUT_LEN (OUT_LEN),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .cfg_val    (cfg_val),
    .cfg_m      (cfg_m),
    .cfg_k      (cfg_k),
    .out_rd_en  (out_rd_en),
    .row_data   (row_data),
    .pe_out_rdy (pe_out_rdy),
    .res        (resIf),
    .done       (done),
    .cfg_err    (cfg_err),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: per-row queues of captured words and the job's m, k and cursor.
  bit                 active    = 1'b0;
  int                 mM        = 0;
  int                 kM        = 0;
  int                 rM        = 1;
  int                 cM        = 1;
  logic [OUT_LEN-1:0] rowMem [X][QMAX];
  int                 rowCnt [X];
  logic [X-1:0]       pend      = '0;
  bit                 expErr    = 1'b0;
  bit                 expDone   = 1'b0;
  bit                 prevStall = 1'b0;
  logic [OUT_LEN-1:0] prevData  = '0;
  logic               prevLast  = 1'b0;
  bit                 ovfCheckEn = 1'b1;
  int                 doneCount = 0;
  logic [OUT_LEN-1:0] gotStream [$];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < X; i++) rowCnt[i] = 0;
    pend = '0;
  endtask

  // One sample per cycle, 1 time unit before the rising edge: outputs from the last
  // edge are settled and the inputs shown are the ones the next edge will see.
  initial begin
    modelClear();
    forever begin
      @(negedge clk);
      #4;
      if (!sys_rst_n) begin
        active    = 1'b0;
        expErr    = 1'b0;
        expDone   = 1'b0;
        prevStall = 1'b0;
        modelClear();
      end else begin
        bit activeNow;
        bit errNext;
        bit doneNext;
        activeNow = active;
        errNext   = 1'b0;
        doneNext  = 1'b0;
        checkOutput("cfg_err", cfg_err, expErr);
        checkOutput("done", done, expDone);
        if (done === 1'b1) doneCount++;
        checkOutput("pe_out_rdy", pe_out_rdy, active);
        if (!active) checkOutput("idle_res_val", resIf.res_val, 0);
        if (ovfCheckEn) checkOutput("ovf_clear_run", ovf, 0);
        if (prevStall) begin
          checkOutput("stall_val", resIf.res_val, 1);
          checkOutput("stall_data", resIf.res_data, prevData);
          checkOutput("stall_last", resIf.res_last, prevLast);
        end
        if (activeNow && resIf.res_val && resIf.res_rdy) begin
          checkOutput("word_available", (cM <= rowCnt[rM-1]), 1);
          if (cM <= rowCnt[rM-1]) checkOutput("res_data", resIf.res_data, rowMem[rM-1][cM-1]);
          checkOutput("res_last", resIf.res_last, (rM == mM && cM == kM));
          gotStream.push_back(resIf.res_data);
          if (rM == mM && cM == kM) begin
            doneNext = 1'b1;
            active   = 1'b0;
          end else if (cM == kM) begin
            cM = 1;
            rM++;
          end else begin
            cM++;
          end
        end
        for (int i = 0; i < X; i++) begin
          if (pend[i] && (i + 1) <= mM && rowCnt[i] < QMAX) begin
            rowMem[i][rowCnt[i]] = row_data[i*OUT_LEN +: OUT_LEN];
            rowCnt[i]++;
          end
        end
        pend = activeNow ? out_rd_en : '0;
        if (cfg_val) begin
          if (!activeNow && cfg_m >= 1 && cfg_m <= X && cfg_k >= 1 && cfg_k <= Y) begin
            mM = int'(cfg_m);
            kM = int'(cfg_k);
            rM = 1;
            cM = 1;
            modelClear();
            active = 1'b1;
          end else begin
            errNext = 1'b1;
          end
        end
        expErr    = errNext;
        expDone   = doneNext;
        prevStall = resIf.res_val && !resIf.res_rdy;
        prevData  = resIf.res_data;
        prevLast  = resIf.res_last;
      end
    end
  end

  task automatic sendCfg(input int m, input int k);
    @(negedge clk);
    cfg_val = 1'b1;
    cfg_m   = CNT_W'(m);
    cfg_k   = CNT_W'(k);
    @(negedge clk);
    cfg_val = 1'b0;
    gotStream.delete();
  endtask

  // Row i strobes cntC[i] cycles from startC[i]; its data follows one cycle later.
  // rdyMode: 0 always ready, 1 one on / two off, 2 random, 3 never, 4 only at cycle 6.
  task automatic applyStimulus(input int startC[X], input int cntC[X], input int rdyMode,
                               input bit randData, input int maxCycles, input bit expectDone,
                               input int injectAt);
    logic [OUT_LEN-1:0] dat [X][8];
    int d0;
    int lastCyc;
    d0      = doneCount;
    lastCyc = 0;
    for (int i = 0; i < X; i++) begin
      for (int c = 0; c < 8; c++)
        dat[i][c] = randData ? OUT_LEN'($urandom) : OUT_LEN'(10 * (i + 1) + (c + 1));
      if (cntC[i] > 0 && startC[i] + cntC[i] > lastCyc) lastCyc = startC[i] + cntC[i];
    end
    for (int j = 0; j < maxCycles; j++) begin
      if (j > lastCyc && doneCount != d0 && j > injectAt) break;
      @(negedge clk);
      out_rd_en = '0;
      row_data  = X*OUT_LEN'($urandom);
      for (int i = 0; i < X; i++) begin
        if (j >= startC[i] && j < startC[i] + cntC[i]) out_rd_en[i] = 1'b1;
        if (j >= startC[i] + 1 && j <= startC[i] + cntC[i])
          row_data[i*OUT_LEN +: OUT_LEN] = dat[i][j - startC[i] - 1];
      end
      case (rdyMode)
        0:       resIf.res_rdy = 1'b1;
        1:       resIf.res_rdy = (j % 3 == 0);
        2:       resIf.res_rdy = 1'($urandom_range(0, 1));
        4:       resIf.res_rdy = (j == 6);
        default: resIf.res_rdy = 1'b0;
      endcase
      if (j == injectAt) begin
        cfg_val = 1'b1;
        cfg_m   = CNT_W'(1);
        cfg_k   = CNT_W'(1);
      end else begin
        cfg_val = 1'b0;
      end
    end
    @(negedge clk);
    out_rd_en     = '0;
    cfg_val       = 1'b0;
    resIf.res_rdy = 1'b0;
    if (expectDone) checkOutput("job_done_in_time", (doneCount != d0), 1);
  endtask

  task automatic checkStream(input string nm, input int expQ[$]);
    checkOutput({nm, "_len"}, gotStream.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < gotStream.size(); i++)
      checkOutput(nm, gotStream[i], expQ[i]);
  endtask

  initial begin
    int st[X];
    int cn[X];
    int e9[$];
    int e4[$];
    int e3[$];
    int e1[$];
    e9 = '{11, 12, 13, 21, 22, 23, 31, 32, 33};
    e4 = '{11, 12, 21, 22};
    e3 = '{11, 12, 13};
    e1 = '{11};

    sys_rst_n     = 1'b0;
    cfg_val       = 1'b0;
    cfg_m         = '0;
    cfg_k         = '0;
    out_rd_en     = '0;
    row_data      = '0;
    resIf.res_rdy = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_res_val", resIf.res_val, 0);
    checkOutput("rst_pe_out_rdy", pe_out_rdy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_cfg_err", cfg_err, 0);
    checkOutput("rst_ovf", ovf, 0);
    @(negedge clk);
    sys_rst_n = 1'b1;

    $display("[TB] reset in the middle of a job");
    sendCfg(3, 3);
    st = '{0, 0, 0};
    cn = '{3, 0, 0};
    applyStimulus(st, cn, 3, 1'b0, 6, 1'b0, -1);
    checkOutput("pre_rst_res_val", resIf.res_val, 1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_res_val", resIf.res_val, 0);
    checkOutput("mid_rst_pe_out_rdy", pe_out_rdy, 0);
    checkOutput("mid_rst_ovf", ovf, 0);
    @(negedge clk);
    sys_rst_n = 1'b1;
    sendCfg(1, 1);
    st = '{0, 0, 0};
    cn = '{1, 0, 0};
    applyStimulus(st, cn, 0, 1'b0, 20, 1'b1, -1);
    checkStream("after_rst_stream", e1);

    $display("[TB] full 3x3 job, consumer always ready");
    sendCfg(3, 3);
    st = '{0, 2, 4};
    cn = '{3, 3, 3};
    applyStimulus(st, cn, 0, 1'b0, 40, 1'b1, -1);
    checkStream("stream_3x3", e9);

    $display("[TB] full 3x3 job, consumer ready 1 of 3 cycles");
    sendCfg(3, 3);
    applyStimulus(st, cn, 1, 1'b0, 60, 1'b1, -1);
    checkStream("stream_3x3_stall", e9);

    $display("[TB] 2x2 job with row 3 strobed");
    sendCfg(2, 2);
    cn = '{2, 2, 2};
    applyStimulus(st, cn, 0, 1'b0, 40, 1'b1, -1);
    checkStream("stream_2x2", e4);
    checkOutput("ovf_2x2", ovf, 0);

    $display("[TB] overflow on a stalled row");
    sendCfg(1, 3);
    ovfCheckEn = 1'b0;
    st = '{0, 0, 0};
    cn = '{6, 0, 0};
    applyStimulus(st, cn, 3, 1'b0, 10, 1'b0, -1);
    checkOutput("ovf_set", ovf, 1);
    cn = '{0, 0, 0};
    applyStimulus(st, cn, 0, 1'b0, 20, 1'b1, -1);
    checkStream("stream_ovf", e3);
    checkOutput("ovf_sticky", ovf, 1);
    sendCfg(1, 3);
    #1;
    checkOutput("ovf_cleared_by_cfg", ovf, 0);
    ovfCheckEn = 1'b1;
    cn = '{6, 0, 0};
    applyStimulus(st, cn, 4, 1'b0, 10, 1'b0, -1);
    checkOutput("ovf_push_pop_full", ovf, 0);
    cn = '{0, 0, 0};
    applyStimulus(st, cn, 0, 1'b0, 20, 1'b1, -1);
    checkStream("stream_push_pop", e3);

    $display("[TB] illegal and ignored configurations");
    sendCfg(0, 1);
    #1;
    checkOutput("cfg_err_m0", cfg_err, 1);
    checkOutput("idle_after_m0", pe_out_rdy, 0);
    sendCfg(1, 4);
    #1;
    checkOutput("cfg_err_k4", cfg_err, 1);
    checkOutput("idle_after_k4", pe_out_rdy, 0);
    sendCfg(3, 3);
    st = '{0, 2, 4};
    cn = '{3, 3, 3};
    applyStimulus(st, cn, 0, 1'b0, 40, 1'b1, 5);
    checkStream("stream_cfg_in_active", e9);

    $display("[TB] randomised jobs");
    for (int n = 0; n < 12; n++) begin
      int rm;
      int rk;
      int inj;
      rm  = $urandom_range(1, X);
      rk  = $urandom_range(1, Y);
      inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : -1;
      for (int i = 0; i < X; i++) begin
        st[i] = $urandom_range(0, 6);
        cn[i] = rk;
      end
      sendCfg(rm, rk);
      applyStimulus(st, cn, 2, 1'b1, 120, 1'b1, inj);
      checkOutput("rand_stream_len", gotStream.size(), rm * rk);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
